lock_monitor: RTL and testbench
===============================

LOCK_MONITOR -- requirements
Module: lock_monitor

Interface
REQ-001 Parameter CTRL_W, default 4: width of up/down event counters, thresholds and lastDiff.
REQ-002 Parameter WIN_W, default 4: observation window length is 2^WIN_W clock cycles.
REQ-003 Parameter LOCK_WINDOWS, default 2: consecutive passing windows required to assert lock (range 1..15).
REQ-004 Parameter UNLOCK_WINDOWS, default 3: consecutive failing windows required to drop lock (range 1..15).
REQ-005 clock  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  monitor run; low holds the monitor idle.
REQ-008 freqUp  input  1  frequency-code increment event, one per cycle high.
REQ-009 freqDn  input  1  frequency-code decrement event, one per cycle high.
REQ-010 lockThreshold  input  CTRL_W  maximum |up-dn| for a passing window.
REQ-011 unlockThreshold  input  CTRL_W  |up-dn| above this is a failing window.
REQ-012 locked  output  1  registered lock indication.
REQ-013 lockLost  output  1  one-cycle pulse on LOCKED->UNLOCKED transition.
REQ-014 windowDone  output  1  one-cycle pulse when a window is evaluated.
REQ-015 lastDiff  output  CTRL_W  |up-dn| of the most recently evaluated window.

Function
REQ-016 Window counter SHALL count 0..2^WIN_W-1 while enable is high; terminal count is the evaluation cycle.
REQ-017 Up and down counters SHALL increment on freqUp/freqDn respectively in non-terminal cycles, saturating at 2^CTRL_W-1; simultaneous freqUp and freqDn increment both.
REQ-018 Events on the terminal cycle SHALL be discarded; window, up and down counters SHALL clear on the clock edge ending the terminal cycle.
REQ-019 At the terminal-cycle edge: diff = |up-dn| computed at CTRL_W bits without wrap; lastDiff <= diff; windowDone pulses high for the following cycle.
REQ-020 Pass = diff <= lockThreshold; fail = diff > unlockThreshold; evaluated independently, so both or neither may hold.
REQ-021 State machine SHALL have two states, UNLOCKED and LOCKED; locked is high exactly in LOCKED.
REQ-022 UNLOCKED: pass increments goodCnt, non-pass clears it; when the increment makes goodCnt equal LOCK_WINDOWS, enter LOCKED and clear goodCnt.
REQ-023 LOCKED: fail increments badCnt, non-fail clears it; when the increment makes badCnt equal UNLOCK_WINDOWS, enter UNLOCKED, clear badCnt, pulse lockLost for one cycle.
REQ-024 locked, lockLost and windowDone SHALL change only on the edge ending a terminal cycle (latency: one edge after the last counted cycle).
REQ-025 enable low SHALL synchronously clear window/up/down/goodCnt/badCnt, force UNLOCKED with no lockLost pulse, and hold lastDiff.
REQ-026 enable rising SHALL start a fresh window at count 0 on the next cycle.

Reset
REQ-027 reset low SHALL asynchronously clear all counters, lastDiff, locked, lockLost, windowDone and state (UNLOCKED), including mid-window; operation restarts from window count 0 after release.

Configuration
REQ-028 Macro LOCK_MONITOR_LOSS_CNT_EN defined: add output lossCount (8 bits), incremented on every lockLost pulse, saturating at 255, cleared only by reset.
REQ-029 Macro undefined: port lossCount and its logic SHALL be absent; all other behaviour identical.

Verification (CTRL_W=4, WIN_W=4, LOCK_WINDOWS=2, UNLOCK_WINDOWS=3, lockThreshold=1, unlockThreshold=3)
REQ-030 No events for 32 cycles after reset -> windowDone at cycles 16 and 32, lastDiff=0, locked rises after 2nd window.
REQ-031 Locked, then 5 up / 0 dn per window for 3 windows -> lastDiff=5, lockLost pulse once after 3rd window, locked=0; with macro lossCount=1.
REQ-032 Locked, windows with diff 5,5,2,5,5 -> badCnt resets on diff 2, locked stays 1.
REQ-033 20 up events in one window -> up counter saturates at 15, lastDiff=15; freqUp=freqDn=1 every cycle -> lastDiff=0.
REQ-034 Event only on terminal cycle -> ignored, lastDiff=0; enable dropped while locked -> locked=0, no lockLost, lastDiff held.
REQ-035 reset asserted mid-window while locked -> all outputs 0 immediately; relock takes exactly 2 full windows after release.

Source files
------------

// File: rtl/lock_monitor.sv
// Lock monitor: counts frequency-code up/down events over fixed windows of
// 2^WIN_W cycles and decides lock/unlock with hysteresis over consecutive
// windows.
// Optional feature: define LOCK_MONITOR_LOSS_CNT_EN to add the 8-bit
// saturating lossCount output that counts lockLost pulses.
module lock_monitor #(
  parameter int unsigned CTRL_W         = 4,
  parameter int unsigned WIN_W          = 4,
  parameter int unsigned LOCK_WINDOWS   = 2,
  parameter int unsigned UNLOCK_WINDOWS = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              freqUp,
  input  logic              freqDn,
  input  logic [CTRL_W-1:0] lockThreshold,
  input  logic [CTRL_W-1:0] unlockThreshold,
  output logic              locked,
  output logic              lockLost,
  output logic              windowDone,
  output logic [CTRL_W-1:0] lastDiff
`ifdef LOCK_MONITOR_LOSS_CNT_EN
  ,
  output logic [7:0]        lossCount
`endif
);

  typedef enum logic {StUnlocked, StLocked} state_e;

  state_e            state_q;
  logic [WIN_W-1:0]  win_q;
  logic [CTRL_W-1:0] up_q;
  logic [CTRL_W-1:0] dn_q;
  logic [3:0]        good_q;
  logic [3:0]        bad_q;
  logic [CTRL_W-1:0] last_diff_q;
  logic              lock_lost_q;
  logic              window_done_q;

  logic              terminal;
  logic [CTRL_W-1:0] diff;
  logic              pass;
  logic              fail;
  logic [3:0]        good_inc;
  logic [3:0]        bad_inc;
  logic              lock_evt;
  logic              lost_evt;

  // Window evaluation: magnitude of up-dn without wrap, plus pass/fail tests.
  always_comb begin
    terminal = enable && (win_q == '1);
    diff     = (up_q >= dn_q) ? (up_q - dn_q) : (dn_q - up_q);
    pass     = (diff <= lockThreshold);
    fail     = (diff > unlockThreshold);
    good_inc = good_q + 4'd1;
    bad_inc  = bad_q + 4'd1;
    lock_evt = terminal && (state_q == StUnlocked) && pass && (good_inc == 4'(LOCK_WINDOWS));
    lost_evt = terminal && (state_q == StLocked) && fail && (bad_inc == 4'(UNLOCK_WINDOWS));
  end

  // Window and saturating event counters; terminal-cycle events are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      win_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else if (!enable || terminal) begin
      win_q <= '0;
      up_q  <= '0;
      dn_q  <= '0;
    end else begin
      win_q <= win_q + 1'b1;
      if (freqUp && (up_q != '1)) up_q <= up_q + 1'b1;
      if (freqDn && (dn_q != '1)) dn_q <= dn_q + 1'b1;
    end
  end

  // Lock FSM with registered status outputs, advanced only at window ends.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StUnlocked;
      good_q        <= '0;
      bad_q         <= '0;
      last_diff_q   <= '0;
      lock_lost_q   <= 1'b0;
      window_done_q <= 1'b0;
    end else if (!enable) begin
      // Idle: drop lock silently, keep the last reported diff.
      state_q       <= StUnlocked;
      good_q        <= '0;
      bad_q         <= '0;
      lock_lost_q   <= 1'b0;
      window_done_q <= 1'b0;
    end else begin
      lock_lost_q   <= 1'b0;
      window_done_q <= terminal;
      if (terminal) begin
        last_diff_q <= diff;
        unique case (state_q)
          StUnlocked: begin
            if (lock_evt) begin
              state_q <= StLocked;
              good_q  <= '0;
            end else if (pass) begin
              good_q <= good_inc;
            end else begin
              good_q <= '0;
            end
          end
          StLocked: begin
            if (lost_evt) begin
              state_q     <= StUnlocked;
              bad_q       <= '0;
              lock_lost_q <= 1'b1;
            end else if (fail) begin
              bad_q <= bad_inc;
            end else begin
              bad_q <= '0;
            end
          end
        endcase
      end
    end
  end

`ifdef LOCK_MONITOR_LOSS_CNT_EN
  logic [7:0] loss_q;

  // Saturating count of lock losses; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      loss_q <= '0;
    end else if (lost_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lossCount = loss_q;
`endif

  assign locked     = (state_q == StLocked);
  assign lockLost   = lock_lost_q;
  assign windowDone = window_done_q;
  assign lastDiff   = last_diff_q;

endmodule

// File: tb/tb_lock_monitor.sv
// Self-checking bench for lock_monitor: directed scenarios plus randomized
// windows, compared against a window-level behavioural model.
module tb_lock_monitor;

  localparam int CW = 4;
  localparam int WW = 4;
  localparam int LW = 2;
  localparam int UW = 3;
  localparam int WIN_LEN = 1 << WW;
  localparam int SAT = (1 << CW) - 1;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          freqUp;
  logic          freqDn;
  logic [CW-1:0] lockThreshold;
  logic [CW-1:0] unlockThreshold;
  logic          locked;
  logic          lockLost;
  logic          windowDone;
  logic [CW-1:0] lastDiff;
`ifdef LOCK_MONITOR_LOSS_CNT_EN
  logic [7:0]    lossCount;
`endif

  lock_monitor #(
    .CTRL_W        (CW),
    .WIN_W         (WW),
    .LOCK_WINDOWS  (LW),
    .UNLOCK_WINDOWS(UW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .freqUp         (freqUp),
    .freqDn         (freqDn),
    .lockThreshold  (lockThreshold),
    .unlockThreshold(unlockThreshold),
    .locked         (locked),
    .lockLost       (lockLost),
    .windowDone     (windowDone),
    .lastDiff       (lastDiff)
`ifdef LOCK_MONITOR_LOSS_CNT_EN
    ,
    .lossCount      (lossCount)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one update per evaluated window.
  int m_locked = 0;
  int m_good   = 0;
  int m_bad    = 0;
  int m_last   = 0;
  int m_loss   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_good   = 0;
    m_bad    = 0;
    m_last   = 0;
    m_loss   = 0;
  endtask

  // One full window. nu/nd are event counts (placed in the first cycles) or,
  // when rnd is set, per-cycle percent probabilities. term_ev fires both
  // events on the evaluation cycle, which must be ignored.
  task automatic do_window(input int nu, input int nd, input bit term_ev, input bit rnd);
    int cu = 0;
    int cd = 0;
    int su, sd, d;
    bit u, dn, pass, fail, exp_lost;
    for (int c = 0; c < WIN_LEN; c++) begin
      if (c < WIN_LEN - 1) begin
        u  = rnd ? ($urandom_range(0, 99) < nu) : (c < nu);
        dn = rnd ? ($urandom_range(0, 99) < nd) : (c < nd);
        cu += int'(u);
        cd += int'(dn);
      end else begin
        u  = term_ev;
        dn = term_ev;
      end
      freqUp = u;
      freqDn = dn;
      step();
      if (c == 0) begin
        check_eq("wd_low_mid", 32'(windowDone), 0);
        check_eq("lost_low_mid", 32'(lockLost), 0);
      end
    end
    freqUp = 1'b0;
    freqDn = 1'b0;
    su = (cu > SAT) ? SAT : cu;
    sd = (cd > SAT) ? SAT : cd;
    d = (su > sd) ? su - sd : sd - su;
    pass = (d <= int'(lockThreshold));
    fail = (d > int'(unlockThreshold));
    exp_lost = 1'b0;
    m_last = d;
    if (m_locked != 0) begin
      if (fail) begin
        m_bad++;
        if (m_bad == UW) begin
          m_locked = 0;
          m_bad = 0;
          exp_lost = 1'b1;
          if (m_loss < 255) m_loss++;
        end
      end else begin
        m_bad = 0;
      end
    end else begin
      if (pass) begin
        m_good++;
        if (m_good == LW) begin
          m_locked = 1;
          m_good = 0;
        end
      end else begin
        m_good = 0;
      end
    end
    check_eq("window_done", 32'(windowDone), 1);
    check_eq("last_diff", 32'(lastDiff), 32'(m_last));
    check_eq("locked", 32'(locked), 32'(m_locked));
    check_eq("lock_lost", 32'(lockLost), 32'(exp_lost));
`ifdef LOCK_MONITOR_LOSS_CNT_EN
    check_eq("loss_count", 32'(lossCount), 32'(m_loss));
`endif
  endtask

  // Drop enable for a few cycles at a window boundary, then restart.
  task automatic pause_enable(input int cycles);
    enable = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      check_eq("dis_locked", 32'(locked), 0);
      check_eq("dis_lost", 32'(lockLost), 0);
      check_eq("dis_wd", 32'(windowDone), 0);
      check_eq("dis_last_held", 32'(lastDiff), 32'(m_last));
    end
    m_locked = 0;
    m_good = 0;
    m_bad = 0;
    enable = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    enable = 1'b0;
    freqUp = 1'b0;
    freqDn = 1'b0;
    lockThreshold = 4'd1;
    unlockThreshold = 4'd3;
    #1;
    check_eq("rst_locked", 32'(locked), 0);
    check_eq("rst_wd", 32'(windowDone), 0);
    check_eq("rst_last", 32'(lastDiff), 0);
    step();
    step();
    reset = 1'b1;
    enable = 1'b1;
    model_reset();

    // Quiet windows lock after the second one.
    do_window(0, 0, 1'b0, 1'b0);
    do_window(0, 0, 1'b0, 1'b0);
    // Hysteresis: the diff-2 window breaks the failing run.
    do_window(5, 0, 1'b0, 1'b0);
    do_window(5, 0, 1'b0, 1'b0);
    do_window(2, 0, 1'b0, 1'b0);
    do_window(5, 0, 1'b0, 1'b0);
    do_window(5, 0, 1'b0, 1'b0);
    // Third consecutive failure loses lock.
    do_window(0, 5, 1'b0, 1'b0);
    // Saturation, balanced events, terminal-only events.
    do_window(20, 0, 1'b1, 1'b0);
    do_window(20, 20, 1'b1, 1'b0);
    do_window(0, 0, 1'b1, 1'b0);
    // Now locked; enable drop must unlock silently.
    pause_enable(3);
    do_window(0, 0, 1'b0, 1'b0);
    do_window(1, 0, 1'b0, 1'b0);

    // Reset mid-window while locked.
    for (int c = 0; c < 5; c++) begin
      freqUp = 1'b1;
      step();
    end
    freqUp = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_eq("amid_locked", 32'(locked), 0);
    check_eq("amid_lost", 32'(lockLost), 0);
    check_eq("amid_wd", 32'(windowDone), 0);
    check_eq("amid_last", 32'(lastDiff), 0);
`ifdef LOCK_MONITOR_LOSS_CNT_EN
    check_eq("amid_loss", 32'(lossCount), 0);
`endif
    model_reset();
    step();
    reset = 1'b1;
    do_window(0, 0, 1'b0, 1'b0);
    do_window(0, 0, 1'b0, 1'b0);

    // Randomized windows with random thresholds and occasional pauses.
    for (int w = 0; w < 40; w++) begin
      int pu, pd;
      lockThreshold = 4'($urandom_range(0, 4));
      unlockThreshold = 4'($urandom_range(1, 6));
      pu = $urandom_range(0, 50);
      pd = ($urandom_range(0, 1) == 1) ? pu : $urandom_range(0, 50);
      do_window(pu, pd, 1'($urandom_range(0, 1)), 1'b1);
      if ($urandom_range(0, 9) == 0) pause_enable(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
